life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
- Generation engine for the 64x48 Game of Life grid.
- Holds the current generation in a register, loads a seed, and computes one new generation per step request.
- Works one row per clock cycle into a shadow buffer, then commits the whole grid at once, so the display stage downstream only ever sees complete generations.
- Output cells vector uses the display's flat layout: index = row*64 + col, bit 0 = top-left, vector declared [0:CELLS-1].

Parameters:
- COLS, 64, grid width in cells.
- ROWS, 48, grid height in cells.
- WRAP, 1, 1 = toroidal edges; 0 = out-of-grid neighbours count as dead.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle request to load seed into the grid.
- seed  in  COLS*ROWS  seed pattern, same [0:N-1] layout as cells.
- step  in  1  single-cycle request to compute one generation.
- cells  out  COLS*ROWS  current committed generation, feeds the display stage.
- busy  out  1  high while a generation is in progress.
- done  out  1  one-cycle pulse when a new generation is committed.
- gen_count  out  16  number of generations since the last load or reset.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: cells=0, gen_count=0, busy=0, done=0, state IDLE, row counter 0. A reset mid-run discards the partial shadow buffer.
- States: IDLE, RUN, COMMIT. busy = (state != IDLE), and busy is registered state.
- IDLE:
  - load=1: cells<=seed, gen_count<=0, stay IDLE.
  - else step=1: row<=0, go to RUN.
- RUN:
  - Each cycle computes next-row[row] from current rows row-1, row and row+1, and writes it into the shadow buffer.
  - row increments each cycle; at row==ROWS-1 go to COMMIT.
- COMMIT:
  - cells<=shadow, gen_count<=gen_count+1 (wraps 0xFFFF->0), done<=1, go to IDLE.
- Latency: step sampled at edge E gives updated cells, done=1 and busy=0 all visible after edge E+ROWS+1 (E+49). done is low in every other cycle.
- Rule: neighbour count n is 0..8 (4-bit sum).
  - A live cell survives iff n is 2 or 3.
  - A dead cell is born iff n == 3.
- Edges:
  - WRAP=1: row and column indices are taken mod ROWS/COLS (row -1 maps to 47, col 64 maps to 0).
  - WRAP=0: neighbours outside the grid read as 0.
- cells never changes during RUN. Reads use the committed grid only.
- step while busy is ignored and not queued.
- load while busy aborts the run: cells<=seed, gen_count<=0, state IDLE, no done pulse.
- load and step in the same cycle: load wins, step is dropped.

Decomposition:
- Shared package/include holds:
  - COLS, ROWS, CELLS=COLS*ROWS and IDX(row,col) index helper;
  - state encoding IDLE=2'd0, RUN=2'd1, COMMIT=2'd2.
- Natural sub-module: life_row, a combinational block.
  - Inputs: three COLS-bit rows (above, current, below) and WRAP.
  - Output: the COLS-bit next row.
  - Column wrap or zero-fill is handled inside life_row.
  - Row selection (mod ROWS or zero row) is handled in life_engine.

Test Plan:
- Blinker: load cells 660,661,662 (row 10, cols 20-22), pulse step.
  - done pulses exactly 49 cycles after step.
  - cells = {597,661,725} only; gen_count=1.
  - A second step returns to {660,661,662}; gen_count=2.
- Still life and L-tromino: load {0,1,64}, step -> {0,1,64,65}. Step again -> unchanged {0,1,64,65}.
- Wrap edge: load {63,0,1}, step.
  - WRAP=1 -> {3008,0,64}.
  - WRAP=0 -> all cells 0.
- Busy rules:
  - step again at cycle 10 of a run -> ignored; exactly one done; gen_count +1.
  - load of {5} at cycle 20 -> cells={5}, gen_count=0, no done, busy=0 next cycle.
- Stability and precedence:
  - cells is sampled every cycle during RUN and must equal the pre-step value until the commit edge.
  - load+step in the same cycle -> seed loaded, busy stays 0.
- Reset mid-run: assert rst at cycle 30 of a run -> next cycle cells=0, gen_count=0, busy=0, done=0. A subsequent load/step works normally.

Source files
------------

// File: rtl/life_engine_pkg.sv
// Shared definitions for the Game of Life generation engine: grid geometry,
// FSM state encoding, the flat cell index helper and the life rule.
package life_engine_pkg;

  localparam int GRID_COLS  = 64;
  localparam int GRID_ROWS  = 48;
  localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Flat index into the display layout: bit 0 is the top-left cell.
  function automatic int IDX(input int row, input int col);
    return row * GRID_COLS + col;
  endfunction

  // A live cell survives with 2 or 3 neighbours; a dead cell is born with 3.
  function automatic logic life_rule(input logic alive, input logic [3:0] n);
    return (n == 4'd3) || (alive && (n == 4'd2));
  endfunction

endpackage

// File: rtl/life_engine_row.sv
// Combinational next-row evaluator. Takes the committed rows above, at and
// below the row being computed and produces that row's next generation.
// Column wrap-around (toroidal) or zero-fill at the left/right edges is
// resolved here; the caller supplies already-selected (or zeroed) rows.
module life_row
  import life_engine_pkg::*;
#(
  parameter int COLS = GRID_COLS,
  parameter bit WRAP = 1'b1
) (
  input  logic [0:COLS-1] above_i,
  input  logic [0:COLS-1] cur_i,
  input  logic [0:COLS-1] below_i,
  output logic [0:COLS-1] next_o
);

  // Read one cell of a row, treating column -1 and COLS as wrapped or dead.
  function automatic logic col_bit(input logic [0:COLS-1] r, input int c);
    logic b;
    if (c < 0) begin
      b = WRAP ? r[COLS-1] : 1'b0;
    end else if (c >= COLS) begin
      b = WRAP ? r[0] : 1'b0;
    end else begin
      b = r[c];
    end
    return b;
  endfunction

  logic [3:0] n_s [COLS];

  // Sum the eight neighbours of every column and apply the life rule.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      n_s[c] = {3'd0, col_bit(above_i, c - 1)} + {3'd0, col_bit(above_i, c)}
             + {3'd0, col_bit(above_i, c + 1)} + {3'd0, col_bit(cur_i, c - 1)}
             + {3'd0, col_bit(cur_i, c + 1)}   + {3'd0, col_bit(below_i, c - 1)}
             + {3'd0, col_bit(below_i, c)}     + {3'd0, col_bit(below_i, c + 1)};
      next_o[c] = life_rule(cur_i[c], n_s[c]);
    end
  end

endmodule

// File: rtl/life_engine.sv
// Game of Life generation engine. Holds the committed grid, loads seeds and,
// on a step request, sweeps one row per cycle into a shadow buffer before
// committing the whole generation in a single cycle, so downstream logic only
// ever observes complete generations.
module life_engine
  import life_engine_pkg::*;
#(
  parameter int COLS = GRID_COLS,
  parameter int ROWS = GRID_ROWS,
  parameter bit WRAP = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [0:COLS*ROWS-1]   seed,
  input  logic                   step,
  output logic [0:COLS*ROWS-1]   cells,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            gen_count
);

  localparam int CELLS = COLS * ROWS;
  localparam int RW    = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_e             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [0:CELLS-1]   cells_q, cells_d;
  logic [0:CELLS-1]   shadow_q, shadow_d;
  logic [15:0]        gen_q, gen_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [RW-1:0]      up_idx_s, dn_idx_s;
  logic               up_ok_s, dn_ok_s;
  logic [0:COLS-1]    above_s, cur_s, below_s, next_row_s;

  // Select the committed rows around the current row; vertical wrap or zero-fill.
  always_comb begin
    up_idx_s = (row_q == '0) ? LAST_ROW : row_q - 1'b1;
    dn_idx_s = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
    up_ok_s  = WRAP || (row_q != '0);
    dn_ok_s  = WRAP || (row_q != LAST_ROW);
    cur_s    = cells_q[row_q * COLS +: COLS];
    if (up_ok_s) begin
      above_s = cells_q[up_idx_s * COLS +: COLS];
    end else begin
      above_s = '0;
    end
    if (dn_ok_s) begin
      below_s = cells_q[dn_idx_s * COLS +: COLS];
    end else begin
      below_s = '0;
    end
  end

  life_row #(
    .COLS (COLS),
    .WRAP (WRAP)
  ) u_row (
    .above_i (above_s),
    .cur_i   (cur_s),
    .below_i (below_s),
    .next_o  (next_row_s)
  );

  // Next-state logic: load has priority and aborts any run without a done pulse.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cells_d  = cells_q;
    shadow_d = shadow_q;
    gen_d    = gen_q;
    done_d   = 1'b0;
    if (load) begin
      cells_d = seed;
      gen_d   = 16'd0;
      state_d = IDLE;
      row_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (step) begin
            row_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          shadow_d[row_q * COLS +: COLS] = next_row_s;
          if (row_q == LAST_ROW) begin
            state_d = COMMIT;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
        COMMIT: begin
          cells_d = shadow_q;
          gen_d   = gen_q + 16'd1;
          done_d  = 1'b1;
          state_d = IDLE;
          row_d   = '0;
        end
        default: begin
          state_d = IDLE;
          row_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset discards any partial shadow buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      cells_q  <= '0;
      shadow_q <= '0;
      gen_q    <= 16'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cells_q  <= cells_d;
      shadow_q <= shadow_d;
      gen_q    <= gen_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign cells     = cells_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine. Two instances (toroidal and
// zero-filled edges) share stimulus. Expected generations are queued when a
// step is driven and compared when done pulses.
module tb_life_engine;
  import life_engine_pkg::*;

  typedef logic [0:GRID_CELLS-1] grid_t;
  typedef struct { grid_t c1; grid_t c0; int gen; } sb_t;
  typedef struct { grid_t seed; grid_t exp1; grid_t exp0; } vec_t;

  logic        clk, rst, load, step;
  grid_t       seed;
  grid_t       cells1, cells0;
  logic        busy1, busy0, done1, done0;
  logic [15:0] gen1, gen0;

  int n_cmp  = 0;
  int n_fail = 0;
  sb_t sbq[$];
  sb_t mon_e;
  vec_t tbl[4];

  life_engine #(.COLS(GRID_COLS), .ROWS(GRID_ROWS), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .load(load), .seed(seed), .step(step),
    .cells(cells1), .busy(busy1), .done(done1), .gen_count(gen1)
  );

  life_engine #(.COLS(GRID_COLS), .ROWS(GRID_ROWS), .WRAP(1'b0)) dut_flat (
    .clk(clk), .rst(rst), .load(load), .seed(seed), .step(step),
    .cells(cells0), .busy(busy0), .done(done0), .gen_count(gen0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic grid_t mk(input int a = -1, input int b = -1,
                               input int c = -1, input int d = -1);
    grid_t g;
    g = '0;
    if (a >= 0) g[a] = 1'b1;
    if (b >= 0) g[b] = 1'b1;
    if (c >= 0) g[c] = 1'b1;
    if (d >= 0) g[d] = 1'b1;
    return g;
  endfunction

  function automatic int first_diff(input grid_t a, input grid_t b);
    for (int i = 0; i < GRID_CELLS; i++) begin
      if (a[i] !== b[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk_grid(input string nm, input grid_t act, input grid_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d live cells, required %0d live cells, first differing cell %0d",
               nm, $countones(act), $countones(exp), first_diff(act, exp));
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && (done1 === 1'b1 || done0 === 1'b1)) begin
      chk_int("done_both_instances", int'(done0), int'(done1));
      if (sbq.size() == 0) begin
        chk_int("unexpected_done", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk_grid("cells_wrap", cells1, mon_e.c1);
        chk_grid("cells_flat", cells0, mon_e.c0);
        chk_int("gen_count_wrap", int'(gen1), mon_e.gen);
        chk_int("gen_count_flat", int'(gen0), mon_e.gen);
      end
    end
  end

  task automatic pulse_load(input grid_t s);
    @(negedge clk);
    seed = s;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Drive a step, check stability/busy each RUN cycle and the done latency.
  // poke > 0 re-pulses step in that cycle of the run (must be ignored).
  task automatic run_step(input grid_t pre, input grid_t e1, input grid_t e0,
                          input int egen, input int poke);
    sb_t e;
    int  lat;
    e.c1 = e1;
    e.c0 = e0;
    e.gen = egen;
    @(negedge clk);
    step = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    step = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k == poke) begin
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      if (done1 === 1'b1) begin
        lat = k;
        break;
      end
      chk_grid("cells_stable_in_run", cells1, pre);
      chk_int("busy_in_run", int'(busy1), 1);
    end
    chk_int("done_latency", lat, 49);
    chk_int("busy_after_commit", int'(busy1), 0);
    @(posedge clk);
    #1;
    chk_int("done_single_cycle", int'(done1), 0);
  endtask

  // Start a run and return after the given number of RUN edges.
  task automatic start_and_wait(input grid_t e1, input int egen, input int cyc);
    sb_t e;
    e.c1 = e1;
    e.c0 = e1;
    e.gen = egen;
    @(negedge clk);
    step = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    step = 1'b0;
    repeat (cyc - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  grid_t blink_h, blink_v, ltro, blk, wrap_h, wrap_v;

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    step = 1'b0;
    seed = '0;

    blink_h = mk(IDX(10, 20), IDX(10, 21), IDX(10, 22));
    blink_v = mk(597, 661, 725);
    ltro    = mk(0, 1, 64);
    blk     = mk(0, 1, 64, 65);
    wrap_h  = mk(63, 0, 1);
    wrap_v  = mk(3008, 0, 64);

    tbl[0] = '{seed: blink_h, exp1: blink_v, exp0: blink_v};
    tbl[1] = '{seed: ltro,    exp1: blk,     exp0: blk};
    tbl[2] = '{seed: blk,     exp1: blk,     exp0: blk};
    tbl[3] = '{seed: wrap_h,  exp1: wrap_v,  exp0: mk()};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_grid("reset_cells", cells1, mk());
    chk_int("reset_gen", int'(gen1), 0);
    chk_int("reset_busy", int'(busy1), 0);
    chk_int("reset_done", int'(done1), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single generations
    for (int i = 0; i < 4; i++) begin
      pulse_load(tbl[i].seed);
      chk_grid("load_cells", cells1, tbl[i].seed);
      chk_int("load_gen", int'(gen1), 0);
      run_step(tbl[i].seed, tbl[i].exp1, tbl[i].exp0, 1, 0);
    end

    // Blinker period two, gen_count advancing
    pulse_load(blink_h);
    run_step(blink_h, blink_v, blink_v, 1, 0);
    run_step(blink_v, blink_h, blink_h, 2, 0);

    // L-tromino becomes a block, then stays put
    pulse_load(ltro);
    run_step(ltro, blk, blk, 1, 0);
    run_step(blk, blk, blk, 2, 0);

    // Step while busy is ignored: exactly one done, gen_count +1
    pulse_load(blink_h);
    run_step(blink_h, blink_v, blink_v, 1, 10);
    repeat (60) @(posedge clk);
    #1;
    chk_int("ignored_step_gen", int'(gen1), 1);
    chk_int("ignored_step_busy", int'(busy1), 0);

    // Load during a run aborts it without a done pulse
    pulse_load(blink_h);
    start_and_wait(blink_v, 1, 20);
    @(negedge clk);
    seed = mk(5);
    load = 1'b1;
    sbq.delete(sbq.size() - 1);
    @(posedge clk);
    #1;
    load = 1'b0;
    chk_grid("abort_cells", cells1, mk(5));
    chk_int("abort_gen", int'(gen1), 0);
    chk_int("abort_busy", int'(busy1), 0);
    chk_int("abort_done", int'(done1), 0);
    repeat (60) @(posedge clk);

    // Load and step together: load wins, no run starts
    @(negedge clk);
    seed = ltro;
    load = 1'b1;
    step = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    step = 1'b0;
    chk_grid("load_step_cells", cells1, ltro);
    chk_int("load_step_busy", int'(busy1), 0);
    repeat (2) @(posedge clk);
    #1;
    chk_int("load_step_busy_later", int'(busy1), 0);
    repeat (60) @(posedge clk);
    #1;
    chk_grid("load_step_cells_later", cells1, ltro);

    // Reset mid-run clears everything; engine works normally afterwards
    pulse_load(blink_h);
    run_step(blink_h, blink_v, blink_v, 1, 0);
    start_and_wait(blink_h, 2, 30);
    @(negedge clk);
    rst = 1'b1;
    sbq.delete(sbq.size() - 1);
    @(posedge clk);
    #1;
    chk_grid("rst_run_cells", cells1, mk());
    chk_int("rst_run_gen", int'(gen1), 0);
    chk_int("rst_run_busy", int'(busy1), 0);
    chk_int("rst_run_done", int'(done1), 0);
    @(negedge clk);
    rst = 1'b0;
    pulse_load(blink_v);
    run_step(blink_v, blink_h, blink_h, 1, 0);

    repeat (5) @(posedge clk);
    #1;
    chk_int("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
